ex_alu_stage: RTL

- Execute stage of the pipelined MIPS-subset core.
- Decodes opcode/funct from the ID/EX register into the 4-bit ALU control code.
- Selects operand B (rt or extended immediate) and drives a 32-bit ALU built from the 1-bit slice chain.
- Registers result, flags and destination into the EX/MEM pipeline register, with stall and flush control.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/alu32.sv | 52 +++++
 rtl/ex_alu_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU control codes, opcode/funct constants and width defaults
package mips_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_AW_DEFAULT = 5;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/alu32.sv
// rtl/alu32.sv - XLEN-wide ripple chain of 1-bit ALU slices with set-less-than feed
module alu32
  import mips_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            carry_out,
  output logic            carry_in_msb
);

  logic [XLEN:0]   carry;
  logic [XLEN-1:0] sum;
  logic            is_set;
  logic            less0;
  logic            ovf;

  assign carry[0]     = ctrl[3];
  assign carry_out    = carry[XLEN];
  assign carry_in_msb = carry[XLEN-1];
  assign is_set       = (ctrl == ALU_SLT) || (ctrl == ALU_SLTU);
  assign ovf          = carry[XLEN] ^ carry[XLEN-1];
  // Only bit 0 sees the comparison outcome; it is taken from the MSB of the chain.
  assign less0        = (ctrl == ALU_SLT) ? (sum[XLEN-1] ^ ovf) : ~carry[XLEN];

  for (genvar i = 0; i < XLEN; i++) begin : g_slice
    logic b_i;
    logic less_i;
    assign b_i          = b[i] ^ ctrl[3];
    assign sum[i]       = a[i] ^ b_i ^ carry[i];
    assign carry[i+1]   = (a[i] & b_i) | (a[i] & carry[i]) | (b_i & carry[i]);
    assign less_i       = (i == 0) ? less0 : 1'b0;

    always_comb begin
      result[i] = 1'b0;
      if (is_set) begin
        result[i] = less_i;
      end else begin
        case (ctrl[1:0])
          2'd0:    result[i] = a[i] & b_i;
          2'd1:    result[i] = a[i] | b_i;
          2'd2:    result[i] = sum[i];
          default: result[i] = a[i] ^ b_i;
        endcase
      end
    end
  end

endmodule

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - execute stage: decode, operand select, ALU and EX/MEM register
module ex_alu_stage
  import mips_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [5:0]        in_op,
  input  logic [5:0]        in_funct,
  input  logic [XLEN-1:0]   in_rs_val,
  input  logic [XLEN-1:0]   in_rt_val,
  input  logic [15:0]       in_imm,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_wr_en,
  output logic [XLEN-1:0]   ex_result,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_zero,
  output logic              ex_ovf,
  output logic              ex_illegal
);

  logic [3:0]      ctrl;
  logic            use_imm;
  logic            zext;
  logic            wr;
  logic            trap_en;
  logic            illegal;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic            carry_out;
  logic            carry_in_msb;
  logic            trap;

  always_comb begin
    ctrl    = ALU_AND;
    use_imm = 1'b1;
    zext    = 1'b0;
    wr      = 1'b1;
    trap_en = 1'b0;
    illegal = 1'b0;
    case (in_op)
      OPC_RTYPE: begin
        use_imm = 1'b0;
        case (in_funct)
          FN_AND:  ctrl = ALU_AND;
          FN_OR:   ctrl = ALU_OR;
          FN_XOR:  ctrl = ALU_XOR;
          FN_ADD:  begin ctrl = ALU_ADD; trap_en = 1'b1; end
          FN_ADDU: ctrl = ALU_ADD;
          FN_SUB:  begin ctrl = ALU_SUB; trap_en = 1'b1; end
          FN_SUBU: ctrl = ALU_SUB;
          FN_SLT:  ctrl = ALU_SLT;
          FN_SLTU: ctrl = ALU_SLTU;
          default: begin illegal = 1'b1; wr = 1'b0; end
        endcase
      end
      OPC_ADDI:  begin ctrl = ALU_ADD; trap_en = 1'b1; end
      OPC_ADDIU: ctrl = ALU_ADD;
      OPC_SLTI:  ctrl = ALU_SLT;
      OPC_SLTIU: ctrl = ALU_SLTU;
      OPC_ANDI:  begin ctrl = ALU_AND; zext = 1'b1; end
      OPC_ORI:   begin ctrl = ALU_OR;  zext = 1'b1; end
      OPC_XORI:  begin ctrl = ALU_XOR; zext = 1'b1; end
      OPC_LW:    ctrl = ALU_ADD;
      OPC_SW:    begin ctrl = ALU_ADD; wr = 1'b0; end
      OPC_BEQ:   begin ctrl = ALU_SUB; use_imm = 1'b0; wr = 1'b0; end
      default:   begin illegal = 1'b1; wr = 1'b0; end
    endcase
  end

  assign imm_ext = zext ? {{(XLEN-16){1'b0}}, in_imm} : {{(XLEN-16){in_imm[15]}}, in_imm};
  assign op_b    = use_imm ? imm_ext : in_rt_val;
  assign trap    = trap_en & (carry_out ^ carry_in_msb);

  alu32 #(.XLEN(XLEN)) u_alu (
    .ctrl         (ctrl),
    .a            (in_rs_val),
    .b            (op_b),
    .result       (alu_result),
    .carry_out    (carry_out),
    .carry_in_msb (carry_in_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_wr_en      <= 1'b0;
      ex_result     <= '0;
      ex_store_data <= '0;
      ex_dest       <= '0;
      ex_ovf        <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (flush) begin
      ex_valid      <= 1'b0;
      ex_wr_en      <= 1'b0;
      ex_result     <= '0;
      ex_store_data <= '0;
      ex_dest       <= '0;
      ex_ovf        <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (!stall) begin
      // A bubble still moves data through but carries no enables or flags.
      ex_valid      <= in_valid;
      ex_wr_en      <= in_valid & wr & ~trap;
      ex_result     <= alu_result;
      ex_store_data <= in_rt_val;
      ex_dest       <= in_dest;
      ex_ovf        <= in_valid & trap;
      ex_illegal    <= in_valid & illegal;
    end
  end

  assign ex_zero = ex_valid && (ex_result == '0);

endmodule
